// File: rtl/uart_tx_sched.sv
// Round-robin UART 8N1 transmit scheduler: NUM_REQ byte streams share one tx line, with packet locking.
// Define UART_TX_SCHED_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_sched #(
  parameter int NUM_REQ = 4,
  parameter int CLK_DIV = 868
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int GW = $clog2(NUM_REQ);
  localparam logic [15:0] DIV_LOAD = 16'(CLK_DIV - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_TX_SCHED_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]    state_reg;
  logic [15:0]   div_reg;
  logic [2:0]    bit_idx_reg;
  logic [7:0]    data_reg;
  logic          tx_reg;
  logic          lock_reg;
  logic [GW-1:0] last_grant_reg;
  logic [GW-1:0] grant_id_reg;

  logic          win_found;
  logic [GW-1:0] win_id;
  logic [GW-1:0] cand;
  logic          accept;
  logic          bit_end;

  // Search downward so the closest requester after last_grant overwrites the others.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    if (lock_reg) begin
      if (req_valid[last_grant_reg]) begin
        win_found = 1'b1;
        win_id    = last_grant_reg;
      end
    end else begin
      for (int k = NUM_REQ; k >= 1; k--) begin
        cand = GW'((int'(last_grant_reg) + k) % NUM_REQ);
        if (req_valid[cand]) begin
          win_found = 1'b1;
          win_id    = cand;
        end
      end
    end
  end

  assign accept  = (state_reg == IDLE) && win_found;
  assign bit_end = (div_reg == 16'd0);

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[win_id] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      div_reg        <= 16'd0;
      bit_idx_reg    <= 3'd0;
      data_reg       <= 8'd0;
      tx_reg         <= 1'b1;
      lock_reg       <= 1'b0;
      last_grant_reg <= GW'(NUM_REQ - 1);
      grant_id_reg   <= '0;
    end else begin
      if (state_reg != IDLE) div_reg <= bit_end ? DIV_LOAD : div_reg - 16'd1;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            data_reg       <= req_data[win_id*8 +: 8];
            grant_id_reg   <= win_id;
            last_grant_reg <= win_id;
            lock_reg       <= ~req_last[win_id];
            tx_reg         <= 1'b0;
            div_reg        <= DIV_LOAD;
            state_reg      <= START;
          end
        end
        START: begin
          if (bit_end) begin
            tx_reg      <= data_reg[0];
            bit_idx_reg <= 3'd0;
            state_reg   <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx_reg == 3'd7) begin
`ifdef UART_TX_SCHED_PARITY_EN
              tx_reg    <= ^data_reg;
              state_reg <= PARITY;
`else
              tx_reg    <= 1'b1;
              state_reg <= STOP;
`endif
            end else begin
              bit_idx_reg <= bit_idx_reg + 3'd1;
              tx_reg      <= data_reg[bit_idx_reg + 3'd1];
            end
          end
        end
`ifdef UART_TX_SCHED_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            tx_reg    <= 1'b1;
            state_reg <= STOP;
          end
        end
`endif
        STOP: begin
          if (bit_end) state_reg <= IDLE;
        end
        default: begin
          tx_reg    <= 1'b1;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign tx       = tx_reg;
  assign busy     = (state_reg != IDLE) | lock_reg;
  assign grant_id = grant_id_reg;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: directed scenarios plus random traffic, checked cycle by cycle
// against a frame-queue reference model (expected tx bits, arbitration and lock rules).
module tb_uart_tx_sched;
  localparam int NR = 4;
  localparam int CD = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NR-1:0] valid = '0;
  logic [NR-1:0] last = '0;
  logic [7:0]    data [NR];
  logic [8*NR-1:0] req_data;
  logic [NR-1:0] req_ready;
  logic          tx;
  logic          busy;
  logic [1:0]    grant_id;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  // Reference model state: pending tx bits of the frame in flight, arbitration pointer, lock.
  bit mq[$];
  int m_last = NR - 1;
  int m_grant = 0;
  bit m_lock = 1'b0;
  int acc_id[$];
  int acc_cyc[$];

  bit            active;
  bit            etx;
  int            win;
  logic [NR-1:0] erdy;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NR; i++) req_data[8*i +: 8] = data[i];
  end

  uart_tx_sched #(.NUM_REQ(NR), .CLK_DIV(CD)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(valid), .req_data(req_data),
    .req_last(last), .req_ready(req_ready), .tx(tx), .busy(busy), .grant_id(grant_id)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic push_frame(input logic [7:0] d);
    for (int j = 0; j < CD; j++) mq.push_back(1'b0);
    for (int b = 0; b < 8; b++)
      for (int j = 0; j < CD; j++) mq.push_back(d[b]);
`ifdef UART_TX_SCHED_PARITY_EN
    for (int j = 0; j < CD; j++) mq.push_back(^d);
`endif
    for (int j = 0; j < CD; j++) mq.push_back(1'b1);
  endtask

  task automatic model_reset();
    mq.delete();
    m_lock  = 1'b0;
    m_last  = NR - 1;
    m_grant = 0;
  endtask

  // One clock cycle: check outputs at the falling edge, advance the model, return just after the rising edge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    active = (mq.size() > 0);
    etx    = active ? mq.pop_front() : 1'b1;
    check("tx", 32'(tx), 32'(etx));
    check("busy", 32'(busy), 32'(active | m_lock));
    check("grant_id", 32'(grant_id), 32'(m_grant));
    erdy = '0;
    win  = -1;
    if (rst_n && !active) begin
      if (m_lock) begin
        if (valid[m_last]) win = m_last;
      end else begin
        for (int k = 1; k <= NR; k++) begin
          if (win < 0 && valid[(m_last + k) % NR]) win = (m_last + k) % NR;
        end
      end
    end
    if (win >= 0) erdy[win] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(erdy));
    if (win >= 0) begin
      push_frame(data[win]);
      m_grant = win;
      m_last  = win;
      m_lock  = ~last[win];
      acc_id.push_back(win);
      acc_cyc.push_back(cyc);
      $display("accept req=%0d data=0x%02h last=%0d cycle=%0d", win, data[win], last[win], cyc);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    run(2);
    rst_n = 1'b1;
  endtask

  int n0;

  initial begin
    for (int i = 0; i < NR; i++) data[i] = 8'h00;
    model_reset();
    run(3);
    rst_n = 1'b1;

    // Idle after reset release.
    run(20);

    // Single byte 0x55 from requester 2.
    n0 = acc_id.size();
    valid[2] = 1'b1; data[2] = 8'h55; last[2] = 1'b1;
    tick();
    valid = '0;
    run(45);
    check("s2_count", 32'(acc_id.size() - n0), 32'd1);
    if (acc_id.size() > n0) check("s2_id", 32'(acc_id[n0]), 32'd2);

    // All four valid with last=1: strict rotation, 41-cycle spacing.
    do_reset();
    n0 = acc_id.size();
    valid = '1; last = '1;
    for (int i = 0; i < NR; i++) data[i] = 8'hA0 + 8'(i);
    run(4 * 41 + 1);
    valid = '0;
    run(45);
    check("s3_count", 32'(acc_id.size() - n0), 32'd5);
    for (int i = 0; i < 5 && n0 + i < acc_id.size(); i++) begin
      check("s3_order", 32'(acc_id[n0 + i]), 32'(i % NR));
      if (i > 0) check("s3_spacing", 32'(acc_cyc[n0 + i] - acc_cyc[n0 + i - 1]), 32'd41);
    end

    // Locked packet from requester 1 holds off requester 0, even across a gap.
    n0 = acc_id.size();
    valid[0] = 1'b1; data[0] = 8'h30; last[0] = 1'b1;
    valid[1] = 1'b1; data[1] = 8'h48; last[1] = 1'b0;
    tick();
    valid[1] = 1'b0;
    run(50);
    valid[1] = 1'b1; data[1] = 8'h69; last[1] = 1'b1;
    tick();
    valid[1] = 1'b0;
    run(45);
    valid = '0;
    run(45);
    check("s4_count", 32'(acc_id.size() - n0), 32'd3);
    if (acc_id.size() >= n0 + 3) begin
      check("s4_first", 32'(acc_id[n0]), 32'd1);
      check("s4_second", 32'(acc_id[n0 + 1]), 32'd1);
      check("s4_third", 32'(acc_id[n0 + 2]), 32'd0);
    end

    // Reset mid-frame (data bit 3 of 0x00, packet lock held).
    valid[0] = 1'b1; data[0] = 8'h00; last[0] = 1'b0;
    tick();
    valid = '0;
    run(18);
    #2 rst_n = 1'b0;
    #1 check("async_reset_tx", 32'(tx), 32'd1);
    model_reset();
    run(2);
    rst_n = 1'b1;
    n0 = acc_id.size();
    valid[0] = 1'b1; data[0] = 8'h5A; last[0] = 1'b1;
    valid[1] = 1'b1; data[1] = 8'h11; last[1] = 1'b1;
    tick();
    valid[0] = 1'b0;
    run(45);
    valid = '0;
    run(45);
    check("s5_count", 32'(acc_id.size() - n0), 32'd2);
    if (acc_id.size() > n0) check("s5_first", 32'(acc_id[n0]), 32'd0);

    // Random traffic: valids toggle freely, random data and packet boundaries.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NR; i++) begin
        valid[i] = ($urandom_range(0, 3) != 0);
        data[i]  = 8'($urandom);
        last[i]  = ($urandom_range(0, 9) < 7);
      end
      tick();
    end
    valid = '0;
    last  = '1;
    run(50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
